// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: multi-digit seven-segment display controller.
// Holds NUM_DIGITS 4-bit digit registers written through a single-cycle
// port (word, digit, control and scroll-in writes) and drives registered
// active-low segment buses with global enable, leading-zero suppression
// and per-digit blinking.
// Optional feature macro: SEG_BLINK_EN (blink counter, blink phase and the
// per-digit blink mask). Without it blink_phase is 0 and the mask reads 0.
module seg_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int ADDR_W     = 3,
  parameter int BLINK_DIV  = 2500000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [1:0]              wr_mode,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic [4*NUM_DIGITS-1:0] digit_value,
  output logic                    blink_phase
);

  localparam logic [1:0] MODE_WORD  = 2'b00;
  localparam logic [1:0] MODE_DIGIT = 2'b01;
  localparam logic [1:0] MODE_CTRL  = 2'b10;
  localparam logic [1:0] MODE_SCRL  = 2'b11;

  // Hex to seven-segment (g..a, 0 = lit).
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic                       ctrl_en_q, ctrl_en_d;
  logic                       ctrl_lz_q, ctrl_lz_d;
  logic [NUM_DIGITS-1:0]      ctrl_blink_s;
  logic                       blink_phase_s;
  logic [7*NUM_DIGITS-1:0]    seg_q, seg_d;
  logic                       ctrl_wr_s;

  assign ctrl_wr_s = wr_en && (wr_mode == MODE_CTRL);

`ifdef SEG_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_DIV);

  logic [NUM_DIGITS-1:0] ctrl_blink_q, ctrl_blink_d;
  logic [CNT_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;

  // Blink divider: a control write restarts it even on a wrap cycle.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (ctrl_wr_s) begin
      blink_cnt_d   = {CNT_W{1'b0}};
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = {CNT_W{1'b0}};
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      blink_phase_d = blink_phase_q;
    end
  end

  // Blink counter, phase and mask registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      blink_cnt_q   <= {CNT_W{1'b0}};
      blink_phase_q <= 1'b0;
      ctrl_blink_q  <= {NUM_DIGITS{1'b0}};
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      ctrl_blink_q  <= ctrl_blink_d;
    end
  end

  assign ctrl_blink_s  = ctrl_blink_q;
  assign blink_phase_s = blink_phase_q;
`else
  assign ctrl_blink_s  = {NUM_DIGITS{1'b0}};
  // BLINK_DIV has no influence when blinking is not built in.
  assign blink_phase_s = (BLINK_DIV < 2) ? 1'b0 : 1'b0;
`endif

  // Next-state decode of the write port.
  always_comb begin
    digit_d   = digit_q;
    ctrl_en_d = ctrl_en_q;
    ctrl_lz_d = ctrl_lz_q;
`ifdef SEG_BLINK_EN
    ctrl_blink_d = ctrl_blink_q;
`endif
    if (wr_en) begin
      case (wr_mode)
        MODE_WORD: begin
          for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = wr_data[4*i +: 4];
        end
        MODE_DIGIT: begin
          // Out-of-range addresses match no digit and are dropped.
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_addr == ADDR_W'(i)) digit_d[i] = wr_data[3:0];
            else                       digit_d[i] = digit_q[i];
          end
        end
        MODE_CTRL: begin
          ctrl_en_d = wr_data[0];
          ctrl_lz_d = wr_data[1];
`ifdef SEG_BLINK_EN
          ctrl_blink_d = wr_data[NUM_DIGITS+1:2];
`endif
        end
        MODE_SCRL: begin
          digit_d[0] = wr_data[3:0];
          for (int i = 1; i < NUM_DIGITS; i++) digit_d[i] = digit_q[i-1];
        end
        default: digit_d = digit_q;
      endcase
    end else begin
      digit_d = digit_q;
    end
  end

  // Segment image: blanking by enable, then blink, then leading zeros.
  always_comb begin
    logic zero_above;
    logic blank;
    seg_d      = {(7*NUM_DIGITS){1'b1}};
    zero_above = 1'b1;
    blank      = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (digit_q[i] == 4'h0);
      if (!ctrl_en_q) begin
        blank = 1'b1;
      end else if (blink_phase_s && ctrl_blink_s[i]) begin
        blank = 1'b1;
      end else if (ctrl_lz_q && zero_above && (i != 0)) begin
        blank = 1'b1;
      end else begin
        blank = 1'b0;
      end
      seg_d[7*i +: 7] = blank ? 7'h7F : hex7(digit_q[i]);
    end
  end

  // Digit, control and segment output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      digit_q   <= {(4*NUM_DIGITS){1'b0}};
      ctrl_en_q <= 1'b1;
      ctrl_lz_q <= 1'b0;
      seg_q     <= {(7*NUM_DIGITS){1'b1}};
    end else begin
      digit_q   <= digit_d;
      ctrl_en_q <= ctrl_en_d;
      ctrl_lz_q <= ctrl_lz_d;
      seg_q     <= seg_d;
    end
  end

  assign seg         = seg_q;
  assign digit_value = digit_q;
  assign blink_phase = blink_phase_s;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: scoreboard bench for seg_display_ctrl with
// NUM_DIGITS=8, ADDR_W=4, BLINK_DIV=4. Blink expectations follow SEG_BLINK_EN.
module tb_seg_display_ctrl;

  localparam int ND = 8;
  localparam int AW = 4;
  localparam int BD = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          wr_en;
  logic [1:0]    wr_mode;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [55:0]   seg;
  logic [31:0]   digit_value;
  logic          blink_phase;

  seg_display_ctrl #(.NUM_DIGITS(ND), .ADDR_W(AW), .BLINK_DIV(BD)) dut (
    .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_mode(wr_mode),
    .wr_addr(wr_addr), .wr_data(wr_data), .seg(seg),
    .digit_value(digit_value), .blink_phase(blink_phase)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [55:0] seg;
    logic [31:0] dv;
    logic        ph;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  // Reference model state
  logic [3:0]    m_dig[ND];
  logic          m_en, m_lz, m_ph;
  logic [ND-1:0] m_blink;
  int            m_cnt;
  logic [55:0]   m_seg;
  logic          saw_ph1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_lut(input logic [3:0] v);
    logic [6:0] t[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic logic [31:0] m_value();
    logic [31:0] v = 32'h0;
    for (int i = 0; i < ND; i++) v[4*i +: 4] = m_dig[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
    m_en = 1'b1; m_lz = 1'b0; m_blink = '0; m_cnt = 0; m_ph = 1'b0;
    m_seg = {56{1'b1}};
    sb_q.delete();
  endtask

  // Advance the model by one clock edge and queue the expected outputs.
  task automatic model_edge(input logic en, input logic [1:0] mode,
                            input logic [AW-1:0] addr, input logic [31:0] data);
    logic [55:0] ns;
    logic        hi_zero;
    logic        dark;
    sb_t         e;
    hi_zero = 1'b1;
    for (int i = ND - 1; i >= 0; i--) begin
      hi_zero = hi_zero && (m_dig[i] == 4'h0);
      dark = !m_en || (m_ph && m_blink[i]) || (m_lz && hi_zero && i > 0);
      ns[7*i +: 7] = dark ? 7'h7F : ref_lut(m_dig[i]);
    end
    if (en) begin
      case (mode)
        2'b00: for (int i = 0; i < ND; i++) m_dig[i] = data[4*i +: 4];
        2'b01: if (int'(addr) < ND) m_dig[addr] = data[3:0];
        2'b10: begin
          m_en = data[0];
          m_lz = data[1];
`ifdef SEG_BLINK_EN
          m_blink = data[ND+1:2];
`endif
        end
        default: begin
          for (int i = ND - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
          m_dig[0] = data[3:0];
        end
      endcase
    end
`ifdef SEG_BLINK_EN
    if (en && mode == 2'b10) begin
      m_cnt = 0; m_ph = 1'b0;
    end else if (m_cnt == BD - 1) begin
      m_cnt = 0; m_ph = ~m_ph;
    end else begin
      m_cnt++;
    end
`endif
    m_seg = ns;
    e.seg = m_seg; e.dv = m_value(); e.ph = m_ph;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, then compare against the scoreboard.
  task automatic step(input logic en, input logic [1:0] mode,
                      input logic [AW-1:0] addr, input logic [31:0] data);
    sb_t e;
    wr_en = en; wr_mode = mode; wr_addr = addr; wr_data = data;
    model_edge(en, mode, addr, data);
    @(posedge clock);
    #1;
    check_val("sb_depth", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val("seg", 64'(seg), 64'(e.seg));
      check_val("digit_value", 64'(digit_value), 64'(e.dv));
      check_val("blink_phase", 64'(blink_phase), 64'(e.ph));
    end
    if (blink_phase) saw_ph1 = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 4'h0, 32'h0);
  endtask

  initial begin
    logic [55:0] exp_seg;
    resetn = 1'b0; wr_en = 1'b0; wr_mode = 2'b00; wr_addr = '0; wr_data = '0;
    saw_ph1 = 1'b0;
    model_reset();

    // Reset held with clock running
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_seg", 64'(seg), 64'(56'hFF_FFFF_FFFF_FFFF));
    check_val("rst_dv", 64'(digit_value), 64'd0);
    check_val("rst_ph", 64'(blink_phase), 64'd0);

    resetn = 1'b1;
    idle(1);
    exp_seg = {8{7'h40}};
    check_val("rel_seg", 64'(seg), 64'(exp_seg));

    // Word write, then digit writes (in range and out of range)
    step(1'b1, 2'b00, 4'h0, 32'h1234_ABCD);
    check_val("word_dv", 64'(digit_value), 64'h1234_ABCD);
    idle(1);
    check_val("word_seg_d0", 64'(seg[6:0]), 64'(7'h21));
    step(1'b1, 2'b01, 4'd7, 32'hF);
    check_val("dig7_dv", 64'(digit_value), 64'hF234_ABCD);
    step(1'b1, 2'b01, 4'd9, 32'h5);
    check_val("dig9_dv", 64'(digit_value), 64'hF234_ABCD);
    step(1'b1, 2'b01, 4'd3, 32'h6);
    idle(1);

    // Scroll-in from zero
    step(1'b1, 2'b00, 4'h0, 32'h0);
    step(1'b1, 2'b11, 4'h0, 32'h1);
    step(1'b1, 2'b11, 4'h0, 32'h2);
    step(1'b1, 2'b11, 4'h0, 32'h3);
    check_val("scroll_dv", 64'(digit_value), 64'h0000_0123);

    // Leading-zero suppression
    step(1'b1, 2'b00, 4'h0, 32'h0000_0120);
    step(1'b1, 2'b10, 4'h0, 32'h3);
    idle(1);
    exp_seg = {{5{7'h7F}}, 7'h79, 7'h24, 7'h40};
    check_val("lz_seg", 64'(seg), 64'(exp_seg));
    step(1'b1, 2'b00, 4'h0, 32'h0);
    idle(1);
    exp_seg = {{7{7'h7F}}, 7'h40};
    check_val("lz_zero_seg", 64'(seg), 64'(exp_seg));

    // Full decode table, lz off
    step(1'b1, 2'b10, 4'h0, 32'h1);
    step(1'b1, 2'b00, 4'h0, 32'h7654_3210);
    idle(1);
    step(1'b1, 2'b00, 4'h0, 32'hFEDC_BA98);
    idle(1);
    check_val("dec_A", 64'(seg[20:14]), 64'(7'h08));
    check_val("dec_F", 64'(seg[55:49]), 64'(7'h0E));

    // Blink digit 0, then a control write on a wrap cycle
    saw_ph1 = 1'b0;
    step(1'b1, 2'b10, 4'h0, 32'h5);
    idle(12);
`ifdef SEG_BLINK_EN
    check_val("blink_seen", 64'(saw_ph1), 64'd1);
`else
    check_val("blink_off", 64'(saw_ph1), 64'd0);
`endif
    step(1'b1, 2'b10, 4'h0, 32'h5);
    idle(3);
    step(1'b1, 2'b10, 4'h0, 32'h5);
    check_val("wrap_ctrl_ph", 64'(blink_phase), 64'd0);
    idle(6);

    // Global disable keeps digit registers
    step(1'b1, 2'b00, 4'h0, 32'h8765_4321);
    step(1'b1, 2'b10, 4'h0, 32'h0);
    idle(1);
    check_val("dis_seg", 64'(seg), 64'(56'hFF_FFFF_FFFF_FFFF));
    check_val("dis_dv", 64'(digit_value), 64'h8765_4321);
    step(1'b1, 2'b10, 4'h0, 32'h1);
    idle(2);

    // Asynchronous reset in the middle of a write cycle
    wr_en = 1'b1; wr_mode = 2'b00; wr_data = 32'hDEAD_BEEF;
    #2 resetn = 1'b0;
    #1;
    check_val("arst_seg", 64'(seg), 64'(56'hFF_FFFF_FFFF_FFFF));
    check_val("arst_dv", 64'(digit_value), 64'd0);
    check_val("arst_ph", 64'(blink_phase), 64'd0);
    #2 resetn = 1'b1;
    wr_en = 1'b0;
    model_reset();
    idle(2);

    // Random traffic against the model
    for (int k = 0; k < 40; k++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), $urandom);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Parametrised multi-digit seven-segment display controller that replaces the per-digit hex decoder instances at the top level. It holds its own digit registers, written by the processor or debug logic through a single-cycle write port. It drives NUM_DIGITS active-low segment buses with:
- whole-word, single-digit and scroll-in writes;
- leading-zero suppression;
- a global enable;
- per-digit blinking.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits driven (1..16)
- ADDR_W, 3, width of wr_addr; must satisfy 2**ADDR_W >= NUM_DIGITS
- BLINK_DIV, 2500000, clock cycles per blink half-period (>= 2)

Ports:
- clock  in  1  single system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, sampled each rising edge
- wr_mode  in  2  write mode:
  - 00 = word write
  - 01 = digit write
  - 10 = control write
  - 11 = scroll-in
- wr_addr  in  ADDR_W  digit index for mode 01 (digit 0 = least significant)
- wr_data  in  4*NUM_DIGITS  write payload
- seg  out  7*NUM_DIGITS  segments for digit i at [7i+6:7i], bit order g..a, 0 = lit
- digit_value  out  4*NUM_DIGITS  current digit registers, readback
- blink_phase  out  1  current blink phase, 1 = blinking digits hidden

## Operation
State:
- digit[i] (4 b each)
- ctrl_en (1 b)
- ctrl_lz (1 b)
- ctrl_blink (NUM_DIGITS b)
- blink counter
- blink_phase

Reset values:
- All digit registers 0.
- ctrl_en=1, ctrl_lz=0, ctrl_blink=0.
- Blink counter 0, blink_phase 0.
- seg all ones (all digits dark).
- digit_value 0.

Writes take effect on the edge where wr_en=1. One write per cycle; the port is always ready.
- **00 (word write):** digit[i] <= wr_data[4i+3:4i] for all i.
- **01 (digit write):** digit[wr_addr] <= wr_data[3:0]. If wr_addr >= NUM_DIGITS, the write is ignored and no state changes.
- **10 (control write):** ctrl_en <= wr_data[0]; ctrl_lz <= wr_data[1]; ctrl_blink <= wr_data[NUM_DIGITS+1:2]. Also clears the blink counter and sets blink_phase to 0.
- **11 (scroll-in):** digit[i] <= digit[i-1] for i>0, digit[0] <= wr_data[3:0]. The old most-significant digit is discarded.

Hex decode (g..a, active-low), including:
- 0=7'h40, 1=7'h79, 2=7'h24, 8=7'h00, A=7'h08, F=7'h0E.
- Full 0-F table per the standard DE2 encoding.

Blanking: a blanked digit outputs 7'h7F. Blanking rules, in priority order:
1. ctrl_en=0: every digit blanked. Digit registers are retained.
2. blink_phase=1 and ctrl_blink[i]=1: digit i blanked.
3. ctrl_lz=1: digit i (i>0) is blanked when digit[i] and every digit above it are 0. Digit 0 is never blanked by this rule.

Blink counter:
- Free-runs 0..BLINK_DIV-1.
- On wrap, it returns to 0 and blink_phase toggles.
- A control write in the same cycle as a wrap wins: counter 0, phase 0.

## Timing
- Digit and control registers update on edge N (wr_en sampled high).
- seg is registered and reflects the new state on edge N+1, so latency is 2 edges from strobe to display.
- digit_value is combinational from the digit registers and is valid after edge N.
- A blink phase change appears on seg one edge after blink_phase toggles.
- resetn assertion at any time, including mid-write: all registers take their reset values immediately (asynchronous). The write is lost.
- Deassertion is treated as synchronous to clock by the top level.

## Configuration
- SEG_BLINK_EN defined: blink counter, blink_phase toggling and ctrl_blink are implemented as described.
- SEG_BLINK_EN undefined:
  - No blink counter is synthesised.
  - blink_phase is tied to 0.
  - ctrl_blink reads as 0 and control-write bits [NUM_DIGITS+1:2] are ignored.
  - All other behaviour is unchanged.

## Test plan
All scenarios use NUM_DIGITS=8, BLINK_DIV=4 and SEG_BLINK_EN defined unless noted.
- **Reset:** hold resetn=0, clock running → seg=56'hFF_FFFF_FFFF_FFFF (all 7'h7F), digit_value=0. Release, one edge → every digit shows 7'h40.
- **Word write then digit write:** word write of 32'h1234_ABCD → digit_value=32'h1234ABCD; seg digit 0 = decode(D) two edges after the strobe. Digit write wr_addr=7, data 4'hF → digit_value=32'hF234ABCD. Digit write wr_addr=9 with ADDR_W=4 → no change.
- **Scroll-in:** from all zeros, scroll-in 1, 2, 3 on consecutive cycles → digit_value=32'h00000123.
- **Leading-zero suppression:** value 32'h00000120, control write 32'h3 → digits 7..3 are 7'h7F; digits 2..0 are 7'h79, 7'h24, 7'h40. Value 0 with lz → only digit 0 lit, at 7'h40.
- **Blink:** control write with ctrl_en=1 and ctrl_blink=8'h01 → blink_phase toggles every 4 cycles; digit 0 alternates decode/7'h7F while the others stay steady. A control write on a wrap cycle → blink_phase=0.
- **Disable and async reset:** control write 32'h0 → all digits 7'h7F and digit_value retained. resetn pulsed low mid-cycle → immediate reset values. With SEG_BLINK_EN undefined, the blink-mask write has no effect and blink_phase stays 0.
